// File: rtl/learn1_pkg.sv
// learn1 half-adder shared types and defaults.
// Optional carry counter is enabled by the LEARN1_CARRY_CNT_EN macro.
package learn1_pkg;

  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] sum2_t;

  function automatic sum2_t ha_sum2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/learn1_ha_cell.sv
// learn1 combinational half-adder cell.
// Used by learn1_adder for both the live outputs and the register inputs.
module learn1_ha_cell
  import learn1_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  sum2_t sum2;

  // Pure combinational sum/carry, {c,s} == a+b.
  always_comb begin
    sum2 = ha_sum2(a, b);
    s    = sum2[0];
    c    = sum2[1];
  end

endmodule

// File: rtl/learn1_adder.sv
// learn1 half adder with a registered result stage.
// Macro LEARN1_CARRY_CNT_EN adds a saturating carry-event counter.
module learn1_adder
  import learn1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic             c,
  output logic             s_q,
  output logic             c_q,
  output logic             q_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic s_d;
  logic c_d;
  logic q_valid_d;
  logic s_int;
  logic c_int;

  learn1_ha_cell u_ha (
    .a (a),
    .b (b),
    .s (s_int),
    .c (c_int)
  );

  assign s = s_int;
  assign c = c_int;

  // Next state of the result register; reset clears it.
  always_comb begin
    s_d       = 1'b0;
    c_d       = 1'b0;
    q_valid_d = 1'b0;
    if (rst_n) begin
      s_d       = s_int;
      c_d       = c_int;
      q_valid_d = 1'b1;
    end
  end

  // One-cycle result register with valid flag.
  always_ff @(posedge clk) begin
    s_q     <= s_d;
    c_q     <= c_d;
    q_valid <= q_valid_d;
  end

`ifdef LEARN1_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count carry events, holding at all-ones; reset wins.
  always_comb begin
    cnt_d = cnt_q;
    if (!rst_n) begin
      cnt_d = '0;
    end else if (c_int && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign carry_cnt = cnt_q;
`else
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_learn1_adder.sv
// Scoreboard bench for learn1_adder.
// Runs against either build of LEARN1_CARRY_CNT_EN.
module tb_learn1_adder;

  typedef struct {
    logic        s;
    logic        c;
    logic        v;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        a;
  logic        b;
  logic        s;
  logic        c;
  logic        s_q;
  logic        c_q;
  logic        q_valid;
  logic [15:0] carry_cnt;
  logic        s2;
  logic        c2;
  logic        s_q2;
  logic        c_q2;
  logic        q_valid2;
  logic [1:0]  carry_cnt2;

  int checks;
  int errors;

  exp_t        sb[$];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  learn1_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .s         (s),
    .c         (c),
    .s_q       (s_q),
    .c_q       (c_q),
    .q_valid   (q_valid),
    .carry_cnt (carry_cnt)
  );

  learn1_adder #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .s         (s2),
    .c         (c2),
    .s_q       (s_q2),
    .c_q       (c_q2),
    .q_valid   (q_valid2),
    .carry_cnt (carry_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic ia, input logic ib, input logic ir);
    exp_t e;
    exp_t g;
    @(negedge clk);
    a     = ia;
    b     = ib;
    rst_n = ir;
    #1;
    chk("s", 32'(s), 32'(ia ^ ib));
    chk("c", 32'(c), 32'(ia & ib));
    if (!ir) begin
      m_cnt  = '0;
      m_cnt2 = '0;
    end else if (ia & ib) begin
`ifdef LEARN1_CARRY_CNT_EN
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
`endif
    end
    e.s    = ir & (ia ^ ib);
    e.c    = ir & ia & ib;
    e.v    = ir;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("s_q", 32'(s_q), 32'(g.s));
    chk("c_q", 32'(c_q), 32'(g.c));
    chk("q_valid", 32'(q_valid), 32'(g.v));
    chk("cnt", 32'(carry_cnt), 32'(g.cnt));
    chk("cnt2", 32'(carry_cnt2), 32'(g.cnt2));
    chk("s_q2", 32'(s_q2), 32'(g.s));
    chk("c_q2", 32'(c_q2), 32'(g.c));
  endtask

  initial begin
    logic [1:0] va [4];
    logic [1:0] vx [4];
    logic [15:0] exp5;
    checks = 0;
    errors = 0;
    m_cnt  = '0;
    m_cnt2 = '0;
    rst_n  = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    va[0] = 2'b00; va[1] = 2'b10; va[2] = 2'b11; va[3] = 2'b01;
    vx[0] = 2'b00; vx[1] = 2'b10; vx[2] = 2'b01; vx[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      a = va[i][1];
      b = va[i][0];
      #1;
      chk("sweep_sc", 32'({s, c}), 32'(vx[i]));
      #1;
    end

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_cnt", 32'(carry_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("reg_c_q", 32'(c_q), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("reg_s_q", 32'(s_q), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_rst_v", 32'(q_valid), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
`ifdef LEARN1_CARRY_CNT_EN
    exp5 = 16'd5;
`else
    exp5 = 16'd0;
`endif
    chk("cnt_five", 32'(carry_cnt), 32'(exp5));
    step(1'b1, 1'b1, 1'b1);
`ifdef LEARN1_CARRY_CNT_EN
    chk("cnt2_sat", 32'(carry_cnt2), 32'd3);
`else
    chk("cnt2_off", 32'(carry_cnt2), 32'd0);
`endif
    step(1'b1, 1'b1, 1'b0);
    chk("cnt_rst", 32'(carry_cnt), 32'd0);

    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(7) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
